multi_rate_tick_gen: RTL and testbench



---
 rtl/multi_rate_tick_gen.sv | 130 +++++++++++++
 tb/tb_multi_rate_tick_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_tick_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multi_rate_tick_gen
//
// Common time base for the game-logic blocks. Two free-running millisecond
// prescalers (normal and turbo) feed NUM_CH independent channels. Each channel
// counts millisecond strobes up to its programmed period, then emits a
// one-cycle tick and toggles a 50 % duty square wave.
//
// Ports:
//   clk            system clock
//   resetN         asynchronous, active-low reset
//   pause          freezes prescalers and channel counters while high
//   turbo[i]       channel i counts the fast strobe instead of the 1 ms strobe
//   restart[i]     synchronous clear of channel i (counter and duty50)
//   period_ms      channel i period at [i*PER_W +: PER_W]; 0 disables it
//   tick[i]        one-cycle pulse per channel period
//   duty50[i]      toggles on every channel tick
//   ms_tick        registered 1 ms strobe (0 while paused)
//   ms_tick_turbo  registered fast strobe (0 while paused)
//
// No valid/ready handshakes: every input is sampled on each rising edge and
// every output is a plain registered level or pulse.
// -----------------------------------------------------------------------------
module multi_rate_tick_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int NUM_CH    = 4,
  parameter int PER_W     = 12,
  parameter int TURBO_DIV = 10
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    pause,
  input  logic [NUM_CH-1:0]       turbo,
  input  logic [NUM_CH-1:0]       restart,
  input  logic [NUM_CH*PER_W-1:0] period_ms,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       duty50,
  output logic                    ms_tick,
  output logic                    ms_tick_turbo
);

  localparam int PRE_TOP  = CLK_HZ / 1000 - 1;
  localparam int FAST_TOP = CLK_HZ / (1000 * TURBO_DIV) - 1;
  localparam int PRE_W    = (PRE_TOP  > 0) ? $clog2(PRE_TOP + 1)  : 1;
  localparam int FAST_W   = (FAST_TOP > 0) ? $clog2(FAST_TOP + 1) : 1;

  localparam logic [PRE_W-1:0]  PRE_TOP_V  = PRE_W'(PRE_TOP);
  localparam logic [FAST_W-1:0] FAST_TOP_V = FAST_W'(FAST_TOP);

  logic              started;
  logic              run;
  logic [PRE_W-1:0]  pre_n;
  logic [FAST_W-1:0] pre_t;
  logic              stb_n;
  logic              stb_t;

  logic [PER_W-1:0]  ch_cnt [NUM_CH];
  logic [PER_W-1:0]  ch_per [NUM_CH];
  logic [NUM_CH-1:0] ch_stb;

  assign stb_n = (pre_n == PRE_TOP_V);
  assign stb_t = (pre_t == FAST_TOP_V);

  // The prescalers start counting one edge after reset release, so the
  // asynchronous deassertion never races the first counting edge. Every
  // later timing point is measured from that first edge.
  assign run = started & ~pause;

  always_comb begin
    ch_stb = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_per[i] = period_ms[i*PER_W +: PER_W];
      ch_stb[i] = turbo[i] ? stb_t : stb_n;
    end
  end

  // Prescalers and the registered strobe copies.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      started       <= 1'b0;
      pre_n         <= '0;
      pre_t         <= '0;
      ms_tick       <= 1'b0;
      ms_tick_turbo <= 1'b0;
    end else begin
      started       <= 1'b1;
      ms_tick       <= run & stb_n;
      ms_tick_turbo <= run & stb_t;
      if (run) begin
        pre_n <= stb_n ? '0 : pre_n + PRE_W'(1);
        pre_t <= stb_t ? '0 : pre_t + FAST_W'(1);
      end
    end
  end

  // Channel counters. The wrap test uses >= so that lowering the period
  // below the current count wraps on the next strobe instead of running
  // the counter all the way round.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt[i] <= '0;
      end
      tick   <= '0;
      duty50 <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        tick[i] <= 1'b0;
        if (restart[i]) begin
          ch_cnt[i] <= '0;
          duty50[i] <= 1'b0;
        end else if (pause) begin
          ch_cnt[i] <= ch_cnt[i];
        end else if (ch_per[i] == '0) begin
          ch_cnt[i] <= '0;
        end else if (ch_stb[i]) begin
          if (ch_cnt[i] >= ch_per[i] - PER_W'(1)) begin
            ch_cnt[i] <= '0;
            tick[i]   <= 1'b1;
            duty50[i] <= ~duty50[i];
          end else begin
            ch_cnt[i] <= ch_cnt[i] + PER_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
`timescale 1ns/1ps
module tb_multi_rate_tick_gen;

  localparam int CLK_HZ    = 20_000;
  localparam int NUM_CH    = 4;
  localparam int PER_W     = 12;
  localparam int TURBO_DIV = 10;

  logic                    clk = 1'b0;
  logic                    resetN;
  logic                    pause;
  logic [NUM_CH-1:0]       turbo;
  logic [NUM_CH-1:0]       restart;
  logic [NUM_CH*PER_W-1:0] period_ms;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       duty50;
  logic                    ms_tick;
  logic                    ms_tick_turbo;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  multi_rate_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .NUM_CH   (NUM_CH),
    .PER_W    (PER_W),
    .TURBO_DIV(TURBO_DIV)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .pause        (pause),
    .turbo        (turbo),
    .restart      (restart),
    .period_ms    (period_ms),
    .tick         (tick),
    .duty50       (duty50),
    .ms_tick      (ms_tick),
    .ms_tick_turbo(ms_tick_turbo)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  // Edge k = k-th rising edge after resetN deasserts.
  always @(posedge clk) begin
    if (!resetN) edge_n <= 0;
    else         edge_n <= edge_n + 1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (edge_n < k) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        errors++;
        $display("FAIL wait_edge timeout target=%0d reached=%0d", k, edge_n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  task automatic do_reset();
    resetN    = 1'b0;
    pause     = 1'b0;
    turbo     = '0;
    restart   = '0;
    period_ms = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      chk("rst_tick", tick[i], 1'b0);
      chk("rst_duty50", duty50[i], 1'b0);
    end
    chk("rst_ms_tick", ms_tick, 1'b0);
    chk("rst_ms_tick_turbo", ms_tick_turbo, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic set_period(input int ch, input int p);
    period_ms[ch*PER_W +: PER_W] = PER_W'(p);
  endtask

  function automatic logic on_grid(input int k, input int first, input int step);
    return (k >= first) && (((k - first) % step) == 0);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    resetN    = 1'b0;
    pause     = 1'b0;
    turbo     = '0;
    restart   = '0;
    period_ms = '0;

    // A: ch0 P=3 normal, ch1 P=5 turbo, ch2 P=10 later lowered to 2 then 0.
    do_reset();
    set_period(0, 3);
    set_period(1, 5);
    set_period(2, 10);
    turbo[1] = 1'b1;
    for (int k = 1; k <= 1130; k++) begin
      wait_edge(k);
      chk("a_tick0", tick[0], on_grid(k, 61, 60));
      chk("a_duty0", duty50[0], logic'(((k - 1) / 60) % 2));
      chk("a_tick1", tick[1], on_grid(k, 11, 10));
      chk("a_tick2", tick[2], logic'(k == 121));
      chk("a_duty2", duty50[2], logic'(k >= 121));
      chk("a_tick3", tick[3], 1'b0);
      chk("a_ms_tick", ms_tick, on_grid(k, 21, 20));
      chk("a_ms_tick_turbo", ms_tick_turbo, on_grid(k, 3, 2));
      if (k == 101) set_period(2, 2);
      if (k == 121) set_period(2, 0);
    end

    // B: ch1 P=5 turbo, turbo dropped so edge 25 uses the normal strobe.
    do_reset();
    set_period(1, 5);
    turbo[1] = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      wait_edge(k);
      chk("b_tick1", tick[1], logic'(k == 11 || k == 21 || k == 101));
      if (k == 24) turbo[1] = 1'b0;
    end

    // C: ch0 P=3, restart sampled on edge 50.
    do_reset();
    set_period(0, 3);
    for (int k = 1; k <= 110; k++) begin
      wait_edge(k);
      chk("c_tick0", tick[0], logic'(k == 101));
      chk("c_duty0", duty50[0], logic'(k >= 101));
      if (k == 49) restart[0] = 1'b1;
      if (k == 50) restart[0] = 1'b0;
    end

    // D: ch0 P=3, pause sampled high on edges 30..129.
    do_reset();
    set_period(0, 3);
    for (int k = 1; k <= 170; k++) begin
      wait_edge(k);
      chk("d_tick0", tick[0], logic'(k == 161));
      chk("d_duty0", duty50[0], logic'(k >= 161));
      if (k < 30)
        chk("d_ms_tick", ms_tick, on_grid(k, 21, 20));
      else if (k <= 129)
        chk("d_ms_tick_paused", ms_tick, 1'b0);
      else
        chk("d_ms_tick", ms_tick, on_grid(k - 100, 21, 20));
      if (k == 29)  pause = 1'b1;
      if (k == 129) pause = 1'b0;
    end

    // E: asynchronous reset in the middle of an active tick.
    do_reset();
    set_period(0, 3);
    wait_edge(61);
    chk("e_tick0_pre", tick[0], 1'b1);
    chk("e_duty0_pre", duty50[0], 1'b1);
    chk("e_ms_pre", ms_tick, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    chk("e_tick0_async", tick[0], 1'b0);
    chk("e_duty0_async", duty50[0], 1'b0);
    chk("e_ms_async", ms_tick, 1'b0);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int k = 1; k <= 190; k++) begin
      wait_edge(k);
      chk("e_tick0", tick[0], on_grid(k, 61, 60));
      chk("e_duty0", duty50[0], logic'(((k - 1) / 60) % 2));
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
